// File: rtl/l1_mmu_arbiter.sv
// -----------------------------------------------------------------------------
// l1_mmu_arbiter
//
// Shares the single MMU memory port between the L1 I-cache and the L1 D-cache.
// One requester is granted at a time. The grant is held until the MMU reports
// completion, and the completion is routed back to the granted requester only.
//
// Handshake semantics (all requests are levels, sampled at posedge sys_clk):
//   A requester raises x_req_* and holds it with a stable address/data until it
//   sees x_done high in a cycle. It then retires the request at that edge.
//   The arbiter latches the request when it grants it. From then on,
//   mmu_req_* come only from the latched copy and stay stable until the edge
//   where mmu_done is sampled high. mmu_read_data is valid only while
//   mmu_done is high. x_done is forwarded combinationally from mmu_done, and
//   only while the granted requester still asserts the granted request. A
//   requester that withdraws therefore never sees a done pulse, but its MMU
//   transaction still runs to completion.
//
// Parameters:
//   ADDR_W - request address width
//   LINE_W - cache line width
//
// Ports:
//   sys_clk, rst_n          clock, synchronous active-low reset
//   i_req_read, i_req_addr  I-cache read request
//   i_done, i_read_data     I-cache completion pulse and read data
//   d_req_read/d_req_write  D-cache read / writeback request (write wins)
//   d_req_addr, d_write_data D-cache address and writeback data
//   d_done, d_read_data     D-cache completion pulse and read data
//   mmu_req_read/write      registered MMU request strobes
//   mmu_req_addr/write_data registered MMU address and write data
//   mmu_done, mmu_read_data MMU completion and read data
//   dbg_state_o             current FSM state (IDLE=0, GRANT_I=1, GRANT_D=2,
//                           RELEASE=3)
// -----------------------------------------------------------------------------
module l1_mmu_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              i_req_read,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_done,
  output logic [LINE_W-1:0] i_read_data,
  input  logic              d_req_read,
  input  logic              d_req_write,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [LINE_W-1:0] d_write_data,
  output logic              d_done,
  output logic [LINE_W-1:0] d_read_data,
  output logic              mmu_req_read,
  output logic              mmu_req_write,
  output logic [ADDR_W-1:0] mmu_req_addr,
  output logic [LINE_W-1:0] mmu_write_data,
  input  logic              mmu_done,
  input  logic [LINE_W-1:0] mmu_read_data,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t            state_q;
  logic              last_grant_q;   // 0 = I was granted last, 1 = D
  logic [ADDR_W-1:0] req_addr_q;
  logic [LINE_W-1:0] req_wdata_q;
  logic              req_is_write_q;
  logic              mmu_rd_q;
  logic              mmu_wr_q;

  logic i_pend;
  logic d_pend;
  logic grant_i_d;
  logic grant_d_d;

  assign i_pend = i_req_read;
  assign d_pend = d_req_read | d_req_write;

  // Round-robin arbitration: if only one side is pending, it wins. On a
  // conflict the side that was not granted last wins.
  always_comb begin
    grant_i_d = 1'b0;
    grant_d_d = 1'b0;
    if (i_pend && (!d_pend || last_grant_q)) begin
      grant_i_d = 1'b1;
    end else if (d_pend) begin
      grant_d_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      last_grant_q   <= 1'b0;
      req_addr_q     <= '0;
      req_wdata_q    <= '0;
      req_is_write_q <= 1'b0;
      mmu_rd_q       <= 1'b0;
      mmu_wr_q       <= 1'b0;
    end else begin
      case (state_q)
        // RELEASE arbitrates on its exit edge. The request sampled at the
        // completion edge was ignored, which lets the served cache retire its
        // request first. Back-to-back transactions therefore get exactly one
        // bubble cycle.
        IDLE, RELEASE: begin
          if (grant_i_d) begin
            state_q        <= GRANT_I;
            last_grant_q   <= 1'b0;
            req_addr_q     <= i_req_addr;
            req_wdata_q    <= '0;
            req_is_write_q <= 1'b0;
            mmu_rd_q       <= 1'b1;
            mmu_wr_q       <= 1'b0;
          end else if (grant_d_d) begin
            // A writeback beats a simultaneous read. The read stays pending
            // and is arbitrated again after this transaction.
            state_q        <= GRANT_D;
            last_grant_q   <= 1'b1;
            req_addr_q     <= d_req_addr;
            req_wdata_q    <= d_req_write ? d_write_data : '0;
            req_is_write_q <= d_req_write;
            mmu_rd_q       <= ~d_req_write;
            mmu_wr_q       <= d_req_write;
          end else begin
            state_q <= IDLE;
          end
        end
        GRANT_I, GRANT_D: begin
          // There is no timeout: the grant lasts as long as the MMU needs.
          if (mmu_done) begin
            state_q        <= RELEASE;
            req_addr_q     <= '0;
            req_wdata_q    <= '0;
            req_is_write_q <= 1'b0;
            mmu_rd_q       <= 1'b0;
            mmu_wr_q       <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mmu_req_read   = mmu_rd_q;
  assign mmu_req_write  = mmu_wr_q;
  assign mmu_req_addr   = req_addr_q;
  assign mmu_write_data = req_wdata_q;

  // Done is suppressed if the granted request was withdrawn. For the D side,
  // the request that must still be asserted is the one that was granted.
  assign i_done = mmu_done && (state_q == GRANT_I) && i_req_read;
  assign d_done = mmu_done && (state_q == GRANT_D) &&
                  (req_is_write_q ? d_req_write : d_req_read);

  assign i_read_data = mmu_read_data;
  assign d_read_data = mmu_read_data;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_l1_mmu_arbiter.sv
module tb_l1_mmu_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT_I = 2'd1;
  localparam logic [1:0] S_GRANT_D = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  // clock / reset
  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic              i_req_read;
  logic [ADDR_W-1:0] i_req_addr;
  logic              i_done;
  logic [LINE_W-1:0] i_read_data;
  logic              d_req_read;
  logic              d_req_write;
  logic [ADDR_W-1:0] d_req_addr;
  logic [LINE_W-1:0] d_write_data;
  logic              d_done;
  logic [LINE_W-1:0] d_read_data;
  logic              mmu_req_read;
  logic              mmu_req_write;
  logic [ADDR_W-1:0] mmu_req_addr;
  logic [LINE_W-1:0] mmu_write_data;
  logic              mmu_done;
  logic [LINE_W-1:0] mmu_read_data;
  logic [1:0]        dbg_state_o;

  l1_mmu_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .sys_clk        (sys_clk),
    .rst_n          (rst_n),
    .i_req_read     (i_req_read),
    .i_req_addr     (i_req_addr),
    .i_done         (i_done),
    .i_read_data    (i_read_data),
    .d_req_read     (d_req_read),
    .d_req_write    (d_req_write),
    .d_req_addr     (d_req_addr),
    .d_write_data   (d_write_data),
    .d_done         (d_done),
    .d_read_data    (d_read_data),
    .mmu_req_read   (mmu_req_read),
    .mmu_req_write  (mmu_req_write),
    .mmu_req_addr   (mmu_req_addr),
    .mmu_write_data (mmu_write_data),
    .mmu_done       (mmu_done),
    .mmu_read_data  (mmu_read_data),
    .dbg_state_o    (dbg_state_o)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [LINE_W-1:0] line_a5;
  logic [LINE_W-1:0] line_wr;
  logic [LINE_W-1:0] line_3c;

  // one cycle: step past the active edge, then sample/drive
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                       input logic [LINE_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    i_req_read    = 1'b0;
    i_req_addr    = '0;
    d_req_read    = 1'b0;
    d_req_write   = 1'b0;
    d_req_addr    = '0;
    d_write_data  = '0;
    mmu_done      = 1'b0;
    mmu_read_data = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // the MMU raises done with data; the tick afterwards is the completion edge
  task automatic mmu_complete(input logic [LINE_W-1:0] data);
    mmu_done      = 1'b1;
    mmu_read_data = data;
    #1;
  endtask

  task automatic mmu_idle();
    mmu_done      = 1'b0;
    mmu_read_data = '0;
  endtask

  initial begin
    line_a5 = {32{8'hA5}};
    line_wr = {8{32'h1234_5678}};
    line_3c = {32{8'h3C}};

    // ---------------- reset state ----------------
    apply_reset();
    check("rst_state", LINE_W'(dbg_state_o), LINE_W'(S_IDLE));
    check("rst_mmu_rd", LINE_W'(mmu_req_read), '0);
    check("rst_mmu_wr", LINE_W'(mmu_req_write), '0);
    check("rst_mmu_addr", LINE_W'(mmu_req_addr), '0);
    check("rst_mmu_wdata", mmu_write_data, '0);
    check("rst_i_done", LINE_W'(i_done), '0);
    check("rst_d_done", LINE_W'(d_done), '0);

    // ---------------- single I read ----------------
    i_req_read = 1'b1;
    i_req_addr = 32'h0040_0020;
    tick();
    check("i1_state", LINE_W'(dbg_state_o), LINE_W'(S_GRANT_I));
    check("i1_rd_c1", LINE_W'(mmu_req_read), 1);
    check("i1_wr_c1", LINE_W'(mmu_req_write), '0);
    check("i1_addr_c1", LINE_W'(mmu_req_addr), LINE_W'(32'h0040_0020));
    tick();
    check("i1_rd_c2", LINE_W'(mmu_req_read), 1);
    tick();
    check("i1_rd_c3", LINE_W'(mmu_req_read), 1);
    mmu_complete(line_a5);
    check("i1_i_done", LINE_W'(i_done), 1);
    check("i1_d_done", LINE_W'(d_done), '0);
    check("i1_rdata", i_read_data, line_a5);
    tick();
    i_req_read = 1'b0;
    mmu_idle();
    #1;
    check("i1_release", LINE_W'(dbg_state_o), LINE_W'(S_RELEASE));
    check("i1_rd_drop", LINE_W'(mmu_req_read), '0);
    check("i1_i_done_rel", LINE_W'(i_done), '0);
    tick();
    check("i1_idle", LINE_W'(dbg_state_o), LINE_W'(S_IDLE));

    // ---------------- simultaneous requests from reset ----------------
    apply_reset();
    i_req_read = 1'b1;
    i_req_addr = 32'h100;
    d_req_read = 1'b1;
    d_req_addr = 32'h200;
    tick();
    check("rr1_state", LINE_W'(dbg_state_o), LINE_W'(S_GRANT_D));
    check("rr1_addr", LINE_W'(mmu_req_addr), LINE_W'(32'h200));
    mmu_complete(line_3c);
    check("rr1_d_done", LINE_W'(d_done), 1);
    check("rr1_i_done", LINE_W'(i_done), '0);
    check("rr1_drdata", d_read_data, line_3c);
    tick();
    mmu_idle();
    check("rr1_bubble", LINE_W'(mmu_req_read), '0);
    tick();
    check("rr2_state", LINE_W'(dbg_state_o), LINE_W'(S_GRANT_I));
    check("rr2_addr", LINE_W'(mmu_req_addr), LINE_W'(32'h100));
    mmu_complete(line_a5);
    check("rr2_i_done", LINE_W'(i_done), 1);
    check("rr2_d_done", LINE_W'(d_done), '0);
    tick();
    mmu_idle();
    check("rr2_bubble", LINE_W'(mmu_req_read), '0);
    tick();
    check("rr3_state", LINE_W'(dbg_state_o), LINE_W'(S_GRANT_D));
    check("rr3_addr", LINE_W'(mmu_req_addr), LINE_W'(32'h200));
    mmu_complete(line_3c);
    tick();
    mmu_idle();
    tick();
    check("rr4_state", LINE_W'(dbg_state_o), LINE_W'(S_GRANT_I));
    check("rr4_addr", LINE_W'(mmu_req_addr), LINE_W'(32'h100));
    mmu_complete(line_a5);
    tick();
    mmu_idle();
    i_req_read = 1'b0;
    d_req_read = 1'b0;

    // ---------------- D write and read together ----------------
    apply_reset();
    d_req_write  = 1'b1;
    d_req_read   = 1'b1;
    d_req_addr   = 32'h300;
    d_write_data = line_wr;
    tick();
    check("dw_wr", LINE_W'(mmu_req_write), 1);
    check("dw_rd", LINE_W'(mmu_req_read), '0);
    check("dw_wdata", mmu_write_data, line_wr);
    check("dw_addr", LINE_W'(mmu_req_addr), LINE_W'(32'h300));
    mmu_complete('0);
    check("dw_d_done", LINE_W'(d_done), 1);
    tick();
    d_req_write = 1'b0;
    mmu_idle();
    tick();
    check("dr_rd", LINE_W'(mmu_req_read), 1);
    check("dr_wr", LINE_W'(mmu_req_write), '0);
    check("dr_addr", LINE_W'(mmu_req_addr), LINE_W'(32'h300));
    mmu_complete(line_3c);
    check("dr_d_done", LINE_W'(d_done), 1);
    tick();
    d_req_read = 1'b0;
    mmu_idle();

    // ---------------- withdrawal ----------------
    apply_reset();
    i_req_read = 1'b1;
    i_req_addr = 32'h500;
    tick();
    check("wd_grant", LINE_W'(dbg_state_o), LINE_W'(S_GRANT_I));
    i_req_read = 1'b0;
    d_req_read = 1'b1;
    d_req_addr = 32'h600;
    tick();
    check("wd_rd_held", LINE_W'(mmu_req_read), 1);
    check("wd_addr_held", LINE_W'(mmu_req_addr), LINE_W'(32'h500));
    mmu_complete(line_a5);
    check("wd_i_done", LINE_W'(i_done), '0);
    check("wd_d_done", LINE_W'(d_done), '0);
    tick();
    mmu_idle();
    check("wd_release", LINE_W'(dbg_state_o), LINE_W'(S_RELEASE));
    tick();
    check("wd_next", LINE_W'(dbg_state_o), LINE_W'(S_GRANT_D));
    check("wd_next_addr", LINE_W'(mmu_req_addr), LINE_W'(32'h600));
    mmu_complete(line_3c);
    tick();
    d_req_read = 1'b0;
    mmu_idle();

    // ---------------- address stability ----------------
    apply_reset();
    i_req_read = 1'b1;
    i_req_addr = 32'h700;
    tick();
    i_req_addr = 32'h7FF;
    tick();
    check("as_addr_c2", LINE_W'(mmu_req_addr), LINE_W'(32'h700));
    i_req_addr = 32'h1234;
    tick();
    check("as_addr_c3", LINE_W'(mmu_req_addr), LINE_W'(32'h700));
    mmu_complete(line_a5);
    check("as_addr_done", LINE_W'(mmu_req_addr), LINE_W'(32'h700));
    check("as_i_done", LINE_W'(i_done), 1);
    tick();
    i_req_read = 1'b0;
    mmu_idle();
    check("as_addr_rel", LINE_W'(mmu_req_addr), '0);

    // ---------------- mid-transaction reset ----------------
    apply_reset();
    i_req_read = 1'b1;
    i_req_addr = 32'h900;
    d_req_read = 1'b1;
    d_req_addr = 32'h800;
    tick();
    check("mr_grant_d", LINE_W'(dbg_state_o), LINE_W'(S_GRANT_D));
    rst_n      = 1'b0;
    d_req_read = 1'b0;
    tick();
    check("mr_state", LINE_W'(dbg_state_o), LINE_W'(S_IDLE));
    check("mr_rd", LINE_W'(mmu_req_read), '0);
    check("mr_addr", LINE_W'(mmu_req_addr), '0);
    check("mr_i_done", LINE_W'(i_done), '0);
    rst_n = 1'b1;
    tick();
    check("mr_grant_i", LINE_W'(dbg_state_o), LINE_W'(S_GRANT_I));
    check("mr_addr_i", LINE_W'(mmu_req_addr), LINE_W'(32'h900));
    mmu_complete(line_a5);
    check("mr_i_done2", LINE_W'(i_done), 1);
    tick();
    idle_inputs();

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/l1_mmu_arbiter.md
# l1_mmu_arbiter

Shares the single MMU memory port between the L1 instruction cache and the L1 data cache. Each cache issues 256-bit line reads, and the D-cache also issues line writebacks. The block grants one requester at a time, holds the grant until the MMU completes, and routes the completion back to that requester only. It sits between both L1 caches and the MMU, so neither cache ever sees the other's traffic.

## Interface
Parameters:
- ADDR_W, 32, request address width
- LINE_W, 256, cache line width

Ports (`rst_n` is synchronous, active-low; clock is `sys_clk`):
- sys_clk  in  1  clock; all state changes on posedge
- rst_n  in  1  synchronous active-low reset
- i_req_read  in  1  I-cache line/MMIO read request, level, posedge-synchronous
- i_req_addr  in  ADDR_W  I-cache request address
- i_done  out  1  I-cache completion pulse
- i_read_data  out  LINE_W  read data to I-cache
- d_req_read  in  1  D-cache read request, level
- d_req_write  in  1  D-cache write request, level
- d_req_addr  in  ADDR_W  D-cache request address
- d_write_data  in  LINE_W  D-cache writeback data
- d_done  out  1  D-cache completion pulse
- d_read_data  out  LINE_W  read data to D-cache
- mmu_req_read  out  1  MMU read request
- mmu_req_write  out  1  MMU write request
- mmu_req_addr  out  ADDR_W  MMU address
- mmu_write_data  out  LINE_W  MMU write data
- mmu_done  in  1  MMU completion; one or more cycles
- mmu_read_data  in  LINE_W  MMU read data, valid while mmu_done

## Operation
- State machine states: IDLE, GRANT_I, GRANT_D, RELEASE.
  - Registers: `state`, `last_grant` (0=I, 1=D).
  - Latched registers: `req_addr`, `req_wdata`, `req_is_write`.
- IDLE:
  - Sample requests at posedge.
  - Only I pending -> GRANT_I.
  - Only D pending (read or write) -> GRANT_D.
  - Both pending -> round-robin: grant the side ≠ `last_grant`.
  - Update `last_grant` on every grant.
- Latching on entry to a GRANT state:
  - Latch address, write data and direction.
  - `mmu_req_*` are driven only from these latched registers and stay stable for the whole grant, even if requester inputs change.
- D-cache direction:
  - d_req_write and d_req_read both high -> write wins.
  - The read remains pending and is arbitrated later.
- GRANT_x:
  - Assert mmu_req_read or mmu_req_write; the other is 0.
  - x_done = mmu_done && x_req still asserted (combinational).
  - The other side's done = 0.
- Completion:
  - Posedge with mmu_done=1 -> RELEASE; mmu_req_* drop to 0 at that edge.
- RELEASE:
  - Ignore all requests for one cycle, so the just-served cache can retire its registered request.
  - Then go to IDLE.
- Withdrawal:
  - If the granted requester deasserts its req before mmu_done, the MMU transaction still runs to completion.
  - Its done pulse is suppressed (not forwarded).
- Read data: i_read_data = d_read_data = mmu_read_data (broadcast). Only the done pulse qualifies it.
- Reset, including mid-transaction:
  - state=IDLE, last_grant=0.
  - All mmu_req_*, req_addr and req_wdata = 0.
  - i_done = d_done = 0.
  - The in-flight transaction is abandoned; the MMU shares rst_n.

## Timing
- Grant latency: request high before posedge T -> mmu_req_* high in the cycle after T (registered). One cycle from request to MMU.
- done forwarding: combinational, same cycle as mmu_done, no latency.
- Gap after completion: mmu_done sampled at edge Tk -> RELEASE for Tk..Tk+1 -> earliest next grant at edge Tk+1. This is a one-cycle bubble between back-to-back transactions.
- Hold time: the grant is held for as many cycles as the MMU keeps mmu_done low. There is no timeout.
- Fairness: with both sides continuously requesting, grants alternate I, D, I, D. No side waits more than one full transaction.
- Reset state: after reset, the first simultaneous conflict is granted to D (last_grant=I).

## Test plan
- **Single I read:** i_req_read=1, addr 0x0040_0020, MMU done after 3 cycles with line 0xA5..A5 -> mmu_req_read=1 for 3 cycles with mmu_req_addr=0x0040_0020. i_done pulses with data A5..A5. d_done stays 0. Then 1 RELEASE cycle.
- **Simultaneous requests from reset:** I read 0x100 and D read 0x200 held high -> order is D(0x200), I(0x100), D, I. Exactly one bubble cycle between transactions.
- **D write and read together:** d_req_write=1, d_req_read=1, addr 0x300, wdata 0x1234.. -> mmu_req_write=1 with wdata 0x1234... After d_done, a separate mmu_req_read to 0x300.
- **Withdrawal:** i_req_read dropped 1 cycle after grant -> mmu_req_read stays high until mmu_done. i_done stays 0. Next grant follows RELEASE.
- **Mid-transaction reset:** rst_n=0 during GRANT_D -> next edge: all outputs 0, state IDLE. After release, a pending I request is granted first.
- **Address stability:** i_req_addr changes during GRANT_I -> mmu_req_addr holds the latched value until done.
